eight_bit_serial_subtractor: RTL



---
 rtl/eight_bit_serial_subtractor_pkg.sv | 20 ++
 rtl/eight_bit_serial_subtractor_full_subtractor.sv | 13 +
 rtl/eight_bit_serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/eight_bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state encoding
// and the width/counter sizing used by the top level.
package eight_bit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 8;

  // The counter must reach WIDTH itself, hence one bit beyond $clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_WIDTH_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/eight_bit_serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: D = A - B - Bin, with the borrow out on Bout.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first through one full-subtractor
// cell; operands captured on start, result held until the next accepted start.
module eight_bit_serial_subtractor
  import eight_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrowout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             bw_q, bw_d;
  logic             borrowout_q, borrowout_d;
  logic             diff_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_full;

  full_subtractor u_cell (
    .A   (a_sr_q[0]),
    .B   (b_sr_q[0]),
    .Bin (bw_q),
    .D   (diff_bit),
    .Bout(bw_next)
  );

  // Partial result fills from the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_full = {diff_bit, res_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    bw_d        = bw_q;
    res_d       = res_q;
    d_d         = d_q;
    borrowout_d = borrowout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          bw_d    = Bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        bw_d   = bw_next;
        res_d  = res_full[WIDTH-1:1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          d_d         = res_full;
          borrowout_d = bw_next;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      bw_q        <= 1'b0;
      res_q       <= '0;
      d_q         <= '0;
      borrowout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      bw_q        <= bw_d;
      res_q       <= res_d;
      d_q         <= d_d;
      borrowout_q <= borrowout_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign D         = d_q;
  assign borrowout = borrowout_q;

endmodule
